// File: rtl/alu_pipe_if.sv
// Issue/result bus between the reservation station and the two-stage ALU.
// The RS drives the issue fields. The ALU drives the common-data-bus result fields.
interface alu_pipe_if #(
  parameter int ROB_W  = 4,
  parameter int TYPE_W = 4
);
  // Issue side (RS -> ALU)
  logic              alu_input;
  logic [TYPE_W-1:0] arith_type;
  logic [31:0]       alu_r1_val;
  logic [31:0]       alu_r2_val;
  logic [ROB_W-1:0]  inst_rob_id;

  // Result side (ALU -> CDB)
  logic              rs_fi;
  logic [31:0]       rs_value;
  logic [ROB_W-1:0]  rs_rob_id;

  // Reservation-station view: issues ops and snoops results.
  modport master (
    output alu_input, arith_type, alu_r1_val, alu_r2_val, inst_rob_id,
    input  rs_fi, rs_value, rs_rob_id
  );

  // ALU view: consumes ops and broadcasts results.
  modport slave (
    input  alu_input, arith_type, alu_r1_val, alu_r2_val, inst_rob_id,
    output rs_fi, rs_value, rs_rob_id
  );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage RV32I integer execution unit.
// S1 captures the issued op. S2 evaluates it and registers the result onto the CDB.
// The unit has no backpressure. rdy_in low freezes both stages.
// rob_clear flushes anything in flight, including an op issued in the same cycle.
module alu_pipe #(
  parameter int ROB_W  = 4,
  parameter int TYPE_W = 4
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         rob_clear,
  alu_pipe_if.slave    bus
);

  localparam logic [TYPE_W-1:0] OP_ADD  = TYPE_W'(0);
  localparam logic [TYPE_W-1:0] OP_SUB  = TYPE_W'(1);
  localparam logic [TYPE_W-1:0] OP_AND  = TYPE_W'(2);
  localparam logic [TYPE_W-1:0] OP_OR   = TYPE_W'(3);
  localparam logic [TYPE_W-1:0] OP_XOR  = TYPE_W'(4);
  localparam logic [TYPE_W-1:0] OP_SLL  = TYPE_W'(5);
  localparam logic [TYPE_W-1:0] OP_SRL  = TYPE_W'(6);
  localparam logic [TYPE_W-1:0] OP_SRA  = TYPE_W'(7);
  localparam logic [TYPE_W-1:0] OP_SLT  = TYPE_W'(8);
  localparam logic [TYPE_W-1:0] OP_SLTU = TYPE_W'(9);
  localparam logic [TYPE_W-1:0] OP_BEQ  = TYPE_W'(10);
  localparam logic [TYPE_W-1:0] OP_BNE  = TYPE_W'(11);
  localparam logic [TYPE_W-1:0] OP_BLT  = TYPE_W'(12);
  localparam logic [TYPE_W-1:0] OP_BGE  = TYPE_W'(13);
  localparam logic [TYPE_W-1:0] OP_BLTU = TYPE_W'(14);
  localparam logic [TYPE_W-1:0] OP_BGEU = TYPE_W'(15);

  // Turns a single condition bit into the 0/1 word that compares and branches return.
  function automatic logic [31:0] flag_word(input logic cond);
    return {31'd0, cond};
  endfunction

  // Evaluates one op. Shifts use only the low five bits of b.
  function automatic logic [31:0] alu_result(
    input logic [TYPE_W-1:0] op,
    input logic [31:0]       a,
    input logic [31:0]       b
  );
    logic [4:0]  shamt;
    logic        lt_signed;
    logic        lt_unsigned;
    logic [31:0] res;
    shamt       = b[4:0];
    lt_signed   = ($signed(a) < $signed(b));
    lt_unsigned = (a < b);
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_SLL:  res = a << shamt;
      OP_SRL:  res = a >> shamt;
      OP_SRA:  res = $unsigned($signed(a) >>> shamt);
      OP_SLT:  res = flag_word(lt_signed);
      OP_SLTU: res = flag_word(lt_unsigned);
      OP_BEQ:  res = flag_word(a == b);
      OP_BNE:  res = flag_word(a != b);
      OP_BLT:  res = flag_word(lt_signed);
      OP_BGE:  res = flag_word(!lt_signed);
      OP_BLTU: res = flag_word(lt_unsigned);
      OP_BGEU: res = flag_word(!lt_unsigned);
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  // Stage 1 registers
  logic              v1_r;
  logic [TYPE_W-1:0] type1_r;
  logic [31:0]       a1_r;
  logic [31:0]       b1_r;
  logic [ROB_W-1:0]  tag1_r;

  // Stage 2 (output) registers
  logic              fi_r;
  logic [31:0]       value_r;
  logic [ROB_W-1:0]  rob_id_r;

  // Combinational stage-2 result
  logic [31:0]       result_s;

  // Stage 1: capture the issued op. A flush kills the valid bit of the op issued this cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      v1_r    <= 1'b0;
      type1_r <= '0;
      a1_r    <= 32'd0;
      b1_r    <= 32'd0;
      tag1_r  <= '0;
    end else if (rdy_in) begin
      v1_r    <= bus.alu_input & ~rob_clear;
      type1_r <= bus.arith_type;
      a1_r    <= bus.alu_r1_val;
      b1_r    <= bus.alu_r2_val;
      tag1_r  <= bus.inst_rob_id;
    end
  end

  // Stage 2 evaluation of the op held in S1.
  always_comb begin
    result_s = 32'd0;
    if (v1_r) begin
      result_s = alu_result(type1_r, a1_r, b1_r);
    end else begin
      result_s = alu_result(type1_r, a1_r, b1_r);
    end
  end

  // Stage 2: register the result onto the CDB. A flush also kills the op currently in S1.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      fi_r     <= 1'b0;
      value_r  <= 32'd0;
      rob_id_r <= '0;
    end else if (rdy_in) begin
      fi_r     <= v1_r & ~rob_clear;
      value_r  <= result_s;
      rob_id_r <= tag1_r;
    end
  end

  assign bus.rs_fi     = fi_r;
  assign bus.rs_value  = value_r;
  assign bus.rs_rob_id = rob_id_r;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe.
module tb_alu_pipe;

  logic clk_in;
  logic rst_in;
  logic rdy_in;
  logic rob_clear;

  int total_checks;
  int failed_checks;

  alu_pipe_if #(.ROB_W(4), .TYPE_W(4)) bus ();

  alu_pipe #(.ROB_W(4), .TYPE_W(4)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .rob_clear (rob_clear),
    .bus       (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    assert (obs === exp) else begin
      failed_checks++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic fi, input logic [31:0] val,
                           input logic [3:0] id);
    check({tag, ".fi"}, {31'd0, bus.rs_fi}, {31'd0, fi});
    check({tag, ".value"}, bus.rs_value, val);
    check({tag, ".id"}, {28'd0, bus.rs_rob_id}, {28'd0, id});
  endtask

  task automatic check_fi(input string tag, input logic fi);
    check({tag, ".fi"}, {31'd0, bus.rs_fi}, {31'd0, fi});
  endtask

  task automatic issue(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag);
    bus.alu_input   = 1'b1;
    bus.arith_type  = t;
    bus.alu_r1_val  = a;
    bus.alu_r2_val  = b;
    bus.inst_rob_id = tag;
  endtask

  task automatic idle();
    bus.alu_input   = 1'b0;
    bus.arith_type  = 4'd0;
    bus.alu_r1_val  = 32'd0;
    bus.alu_r2_val  = 32'd0;
    bus.inst_rob_id = 4'd0;
  endtask

  logic [3:0]  vt [13];
  logic [31:0] va [13];
  logic [31:0] vb [13];
  logic [31:0] ve [13];

  initial begin
    total_checks  = 0;
    failed_checks = 0;
    rst_in    = 1'b1;
    rdy_in    = 1'b1;
    rob_clear = 1'b0;
    idle();

    // Reset, then idle
    step();
    step();
    check_out("reset", 1'b0, 32'd0, 4'd0);
    rst_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_out("idle", 1'b0, 32'd0, 4'd0);
    end

    // Single ADD with wraparound
    issue(4'd0, 32'hFFFF_FFFF, 32'd1, 4'd3);
    step();
    idle();
    step();
    check_out("add_wrap", 1'b1, 32'd0, 4'd3);
    step();
    check_fi("add_wrap_end", 1'b0);

    // Back-to-back stream
    issue(4'd1, 32'd5, 32'd7, 4'd1);
    step();
    issue(4'd7, 32'h8000_0000, 32'h0000_0024, 4'd2);
    step();
    check_out("b2b_sub", 1'b1, 32'hFFFF_FFFE, 4'd1);
    issue(4'd9, 32'd1, 32'hFFFF_FFFF, 4'd4);
    step();
    check_out("b2b_sra", 1'b1, 32'hF800_0000, 4'd2);
    issue(4'd12, 32'd1, 32'hFFFF_FFFF, 4'd5);
    step();
    check_out("b2b_sltu", 1'b1, 32'd1, 4'd4);
    idle();
    step();
    check_out("b2b_blt", 1'b1, 32'd0, 4'd5);
    step();
    check_fi("b2b_end", 1'b0);

    // Remaining ops, one at a time
    vt[0]  = 4'd2;  va[0]  = 32'hFF00_FF00; vb[0]  = 32'h0F0F_0F0F; ve[0]  = 32'h0F00_0F00;
    vt[1]  = 4'd3;  va[1]  = 32'hF000_0000; vb[1]  = 32'h0000_000F; ve[1]  = 32'hF000_000F;
    vt[2]  = 4'd4;  va[2]  = 32'hFFFF_0000; vb[2]  = 32'h0F0F_0F0F; ve[2]  = 32'hF0F0_0F0F;
    vt[3]  = 4'd5;  va[3]  = 32'h0000_0003; vb[3]  = 32'h0000_0021; ve[3]  = 32'h0000_0006;
    vt[4]  = 4'd6;  va[4]  = 32'h8000_0000; vb[4]  = 32'h0000_0004; ve[4]  = 32'h0800_0000;
    vt[5]  = 4'd8;  va[5]  = 32'hFFFF_FFFF; vb[5]  = 32'h0000_0001; ve[5]  = 32'd1;
    vt[6]  = 4'd9;  va[6]  = 32'hFFFF_FFFF; vb[6]  = 32'h0000_0001; ve[6]  = 32'd0;
    vt[7]  = 4'd10; va[7]  = 32'h0000_0005; vb[7]  = 32'h0000_0005; ve[7]  = 32'd1;
    vt[8]  = 4'd11; va[8]  = 32'h0000_0005; vb[8]  = 32'h0000_0005; ve[8]  = 32'd0;
    vt[9]  = 4'd13; va[9]  = 32'hFFFF_FFFE; vb[9]  = 32'h0000_0001; ve[9]  = 32'd0;
    vt[10] = 4'd14; va[10] = 32'h0000_0001; vb[10] = 32'hFFFF_FFFE; ve[10] = 32'd1;
    vt[11] = 4'd15; va[11] = 32'hFFFF_FFFE; vb[11] = 32'h0000_0001; ve[11] = 32'd1;
    vt[12] = 4'd13; va[12] = 32'h0000_0003; vb[12] = 32'h0000_0003; ve[12] = 32'd1;
    for (int i = 0; i < 13; i++) begin
      issue(vt[i], va[i], vb[i], 4'(i + 1));
      step();
      idle();
      step();
      check_out($sformatf("op%0d", vt[i]), 1'b1, ve[i], 4'(i + 1));
    end
    step();

    // Stall while the op sits in S1
    issue(4'd0, 32'd2, 32'd3, 4'd6);
    step();
    rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.alu_input   = (k != 1);
      bus.arith_type  = 4'd1;
      bus.alu_r1_val  = 32'd99;
      bus.alu_r2_val  = 32'd1;
      bus.inst_rob_id = 4'd15;
      step();
      check_fi("stall_s1", 1'b0);
    end
    rdy_in = 1'b1;
    idle();
    step();
    check_out("stall_resume", 1'b1, 32'd5, 4'd6);
    step();
    check_fi("stall_once", 1'b0);

    // Stall while a valid result is on the bus
    issue(4'd0, 32'd10, 32'd20, 4'd10);
    step();
    idle();
    step();
    check_out("hold_pre", 1'b1, 32'd30, 4'd10);
    rdy_in = 1'b0;
    step();
    step();
    check_out("hold_stall", 1'b1, 32'd30, 4'd10);
    rdy_in = 1'b1;
    step();
    check_fi("hold_release", 1'b0);

    // Flush: XOR in S1, OR issued together with the clear
    issue(4'd4, 32'h1234_5678, 32'hFFFF_FFFF, 4'd7);
    step();
    issue(4'd3, 32'h0000_00F0, 32'h0000_000F, 4'd8);
    rob_clear = 1'b1;
    step();
    rob_clear = 1'b0;
    check_fi("flush_n1", 1'b0);
    issue(4'd2, 32'h0000_F0F0, 32'h0000_FF00, 4'd11);
    step();
    check_fi("flush_n2", 1'b0);
    idle();
    step();
    check_out("flush_after", 1'b1, 32'h0000_F000, 4'd11);
    step();

    // Flush while stalled is ignored
    issue(4'd5, 32'd1, 32'd31, 4'd12);
    step();
    idle();
    rdy_in    = 1'b0;
    rob_clear = 1'b1;
    step();
    rdy_in    = 1'b1;
    rob_clear = 1'b0;
    step();
    check_out("clear_stalled", 1'b1, 32'h8000_0000, 4'd12);
    step();

    // Async reset mid-cycle with BEQ in S1
    issue(4'd0, 32'd7, 32'd8, 4'd13);
    step();
    issue(4'd10, 32'h0000_1234, 32'h0000_1234, 4'd9);
    step();
    idle();
    check_out("pre_reset", 1'b1, 32'd15, 4'd13);
    #2;
    rst_in = 1'b1;
    #1;
    check_out("async_reset", 1'b0, 32'd0, 4'd0);
    step();
    rst_in = 1'b0;
    step();
    check_out("post_reset1", 1'b0, 32'd0, 4'd0);
    step();
    check_fi("post_reset2", 1'b0);

    $display("%0d/%0d checks passed", total_checks - failed_checks, total_checks);
    $finish;
  end

endmodule
